// File: rtl/alu_seq_core.sv
// Sequential signed ALU: single-cycle add/sub/logic, WIDTH-cycle shift-add multiply
// and restoring divide, with valid/ready handshakes on both sides.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// EXEC  | operation in progress (setup cycle, then WIDTH iterations for MUL/DIV)
// DONE  | result/flags held, out_valid high until out_ready
module alu_seq_core #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2:0]           op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic [WIDTH-1:0]     remainder,
    output logic                 flag_zero,
    output logic                 flag_neg,
    output logic                 flag_ovf,
    output logic                 flag_div0
);

    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;

    function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    // True when a 2*WIDTH signed value is representable in WIDTH signed bits.
    function automatic logic fits_w(input logic [W2-1:0] x);
        logic [WIDTH:0] top;
        top = x[W2-1:WIDTH-1];
        return (top == '0) || (top == '1);
    endfunction

    logic [1:0]        state_q, state_d;
    logic              phase_q, phase_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic [W2-1:0]     acc_q, acc_d;
    logic [W2-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]  work_q, work_d;
    logic [WIDTH:0]    prem_q, prem_d;
    logic [WIDTH-1:0]  dvsr_q, dvsr_d;
    logic              sign_q, sign_d;
    logic [W2-1:0]     result_q, result_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic              fzero_q, fzero_d;
    logic              fneg_q, fneg_d;
    logic              fovf_q, fovf_d;
    logic              fdiv0_q, fdiv0_d;

    logic [WIDTH-1:0]  sum_w, diff_w;
    logic [W2-1:0]     acc_step, mul_res, div_res;
    logic [WIDTH:0]    r_shift, trial, prem_next;
    logic [WIDTH-1:0]  quo_next, div_rem;
    logic [W2-1:0]     fin_res;
    logic [WIDTH-1:0]  fin_rem;
    logic              fin_ovf, fin_div0, fin_en;

    // Datapath step values: one shift-add / restoring-divide iteration from current state.
    always_comb begin
        sum_w     = a_q + b_q;
        diff_w    = a_q - b_q;
        acc_step  = work_q[0] ? (acc_q + mcand_q) : acc_q;
        mul_res   = sign_q ? -acc_step : acc_step;
        r_shift   = {prem_q[WIDTH-1:0], work_q[WIDTH-1]};
        trial     = r_shift - {1'b0, dvsr_q};
        prem_next = trial[WIDTH] ? r_shift : trial;
        quo_next  = {work_q[WIDTH-2:0], ~trial[WIDTH]};
        div_res   = sign_q ? -{{WIDTH{1'b0}}, quo_next} : {{WIDTH{1'b0}}, quo_next};
        div_rem   = a_q[WIDTH-1] ? -prem_next[WIDTH-1:0] : prem_next[WIDTH-1:0];
    end

    always_comb begin
        fin_res  = '0;
        fin_rem  = '0;
        fin_ovf  = 1'b0;
        fin_div0 = 1'b0;
        case (op_q)
            OP_ADD: begin
                fin_res = {{WIDTH{sum_w[WIDTH-1]}}, sum_w};
                fin_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                fin_res = {{WIDTH{diff_w[WIDTH-1]}}, diff_w};
                fin_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_MUL: begin
                fin_res = mul_res;
                fin_ovf = !fits_w(mul_res);
            end
            OP_DIV: begin
                if (b_q == '0) begin
                    fin_rem  = a_q;
                    fin_div0 = 1'b1;
                end else begin
                    fin_res = div_res;
                    fin_rem = div_rem;
                    fin_ovf = !fits_w(div_res);
                end
            end
            OP_AND:  fin_res = {{WIDTH{1'b0}}, a_q & b_q};
            OP_OR:   fin_res = {{WIDTH{1'b0}}, a_q | b_q};
            OP_XOR:  fin_res = {{WIDTH{1'b0}}, a_q ^ b_q};
            default: fin_res = {{WIDTH{1'b0}}, ~(a_q & b_q)};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        work_d   = work_q;
        prem_d   = prem_q;
        dvsr_d   = dvsr_q;
        sign_d   = sign_q;
        result_d = result_q;
        rem_d    = rem_q;
        fzero_d  = fzero_q;
        fneg_d   = fneg_q;
        fovf_d   = fovf_q;
        fdiv0_d  = fdiv0_q;
        fin_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    phase_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (op_q == OP_MUL || op_q == OP_DIV) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        cnt_d   = '0;
                        acc_d   = '0;
                        prem_d  = '0;
                        mcand_d = {{WIDTH{1'b0}}, mag_w(a_q)};
                        work_d  = (op_q == OP_MUL) ? mag_w(b_q) : mag_w(a_q);
                        dvsr_d  = mag_w(b_q);
                        sign_d  = a_q[WIDTH-1] ^ b_q[WIDTH-1];
                    end else begin
                        if (op_q == OP_MUL) begin
                            acc_d   = acc_step;
                            mcand_d = mcand_q << 1;
                            work_d  = work_q >> 1;
                        end else if (b_q != '0) begin
                            prem_d = prem_next;
                            work_d = quo_next;
                        end
                        cnt_d = cnt_q + CW'(1);
                        // The last iteration's step values are folded straight into the result.
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            cnt_d   = '0;
                            fin_en  = 1'b1;
                            state_d = ST_DONE;
                        end
                    end
                end else begin
                    fin_en  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (fin_en) begin
            result_d = fin_res;
            rem_d    = fin_rem;
            fzero_d  = (fin_res == '0);
            fneg_d   = fin_res[W2-1];
            fovf_d   = fin_ovf;
            fdiv0_d  = fin_div0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            phase_q  <= 1'b0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            work_q   <= '0;
            prem_q   <= '0;
            dvsr_q   <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            rem_q    <= '0;
            fzero_q  <= 1'b0;
            fneg_q   <= 1'b0;
            fovf_q   <= 1'b0;
            fdiv0_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            work_q   <= work_d;
            prem_q   <= prem_d;
            dvsr_q   <= dvsr_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            fzero_q  <= fzero_d;
            fneg_q   <= fneg_d;
            fovf_q   <= fovf_d;
            fdiv0_q  <= fdiv0_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign remainder = rem_q;
    assign flag_zero = fzero_q;
    assign flag_neg  = fneg_q;
    assign flag_ovf  = fovf_q;
    assign flag_div0 = fdiv0_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed bench for alu_seq_core at WIDTH=8: latency, arithmetic/logic results,
// flags, DONE hold behaviour and asynchronous reset mid-operation.
module tb_alu_seq_core;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic [2:0]     op = '0;
    logic           in_ready, out_valid;
    logic [2*W-1:0] result;
    logic [W-1:0]   remainder;
    logic           flag_zero, flag_neg, flag_ovf, flag_div0;

    int checks = 0;
    int failures = 0;
    int lat;

    alu_seq_core #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .remainder(remainder), .flag_zero(flag_zero),
        .flag_neg(flag_neg), .flag_ovf(flag_ovf), .flag_div0(flag_div0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one operation, wait for the accept edge, then count edges until out_valid.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [2:0] top,
                          output int latency);
        @(negedge clk);
        a = ta; b = tb; op = top; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        latency = 0;
        while (out_valid !== 1'b1 && latency < 40) begin
            @(posedge clk); #1;
            latency++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        // reset values
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {remainder, flag_zero, flag_neg, flag_ovf, flag_div0}, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_in_ready", in_ready, 1);

        // ADD 100+50 wraps to -106
        run_op(8'd100, 8'd50, 3'b000, lat);
        chk("add_lat", lat, 1);
        chk("add_res", result, 16'hFF96);
        chk("add_ovf", flag_ovf, 1);
        chk("add_neg", flag_neg, 1);
        chk("add_zero", flag_zero, 0);
        consume();
        chk("add_in_ready_after", in_ready, 1);

        // SUB -128-1 wraps to +127
        run_op(8'h80, 8'h01, 3'b001, lat);
        chk("sub_res", result, 16'h007F);
        chk("sub_ovf_neg", {flag_ovf, flag_neg}, 2'b10);
        consume();

        // MUL -7*12 = -84, inside signed 8-bit range
        run_op(8'hF9, 8'd12, 3'b010, lat);
        chk("mul_lat", lat, 9);
        chk("mul_res", result, 16'hFFAC);
        chk("mul_ovf", flag_ovf, 0);
        chk("mul_neg", flag_neg, 1);
        chk("mul_rem", remainder, 0);
        consume();

        // MUL 20*10 = 200 exceeds signed 8-bit range
        run_op(8'd20, 8'd10, 3'b010, lat);
        chk("mul2_res", result, 16'h00C8);
        chk("mul2_ovf", flag_ovf, 1);
        consume();

        // MUL -128*-128 = 16384
        run_op(8'h80, 8'h80, 3'b010, lat);
        chk("mul3_res", result, 16'h4000);
        chk("mul3_flags", {flag_ovf, flag_neg, flag_zero}, 3'b100);
        consume();

        // DIV -100/7 = -14 rem -2
        run_op(8'h9C, 8'd7, 3'b011, lat);
        chk("div_lat", lat, 9);
        chk("div_res", result, 16'hFFF2);
        chk("div_rem", remainder, 8'hFE);
        chk("div_ovf", flag_ovf, 0);
        consume();

        // DIV -128/-1 = +128
        run_op(8'h80, 8'hFF, 3'b011, lat);
        chk("divmin_res", result, 16'h0080);
        chk("divmin_rem", remainder, 8'h00);
        chk("divmin_flags", {flag_ovf, flag_neg, flag_div0}, 3'b100);
        consume();

        // DIV by zero
        run_op(8'd25, 8'd0, 3'b011, lat);
        chk("div0_lat", lat, 9);
        chk("div0_res", result, 16'h0000);
        chk("div0_rem", remainder, 8'h19);
        chk("div0_flags", {flag_div0, flag_zero, flag_ovf}, 3'b110);
        consume();

        // logic ops are zero-extended
        run_op(8'h80, 8'h01, 3'b101, lat);
        chk("or_res", result, 16'h0081);
        chk("or_neg", flag_neg, 0);
        consume();
        run_op(8'h5A, 8'h5A, 3'b110, lat);
        chk("xor_zero", {result, flag_zero}, {16'h0000, 1'b1});
        consume();

        // NAND, then hold DONE for 5 cycles with a competing in_valid
        run_op(8'hF0, 8'h3C, 3'b111, lat);
        chk("nand_lat", lat, 1);
        chk("nand_res", result, 16'h00CF);
        a = 8'h11; b = 8'h22; op = 3'b000; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_state", {out_valid, in_ready}, 2'b10);
            chk("hold_res", {result, remainder, flag_zero, flag_neg, flag_ovf, flag_div0},
                {16'h00CF, 8'h00, 4'b0000});
        end
        in_valid = 1'b0;
        consume();
        chk("nand_release", {in_ready, out_valid}, 2'b10);

        // async reset during MUL iteration 3
        @(negedge clk);
        a = 8'd13; b = 8'd11; op = 3'b010; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_result", result, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_state", {in_ready, out_valid}, 2'b10);

        run_op(8'd3, 8'd4, 3'b000, lat);
        chk("post_add_lat", lat, 1);
        chk("post_add_res", result, 16'h0007);
        chk("post_add_flags", {flag_zero, flag_neg, flag_ovf, flag_div0}, 4'b0000);
        consume();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
